// File: rtl/fc_layer_mac.sv
// -----------------------------------------------------------------------------
// fc_layer_mac
// Fully-connected layer engine. The block accepts one input activation per
// valid/ready handshake. It multiplies that activation by N_OUT weights, which
// it fetches from an external synchronous ROM with one cycle of read latency.
// The products go into N_OUT signed Q-format accumulators. When the run ends,
// each accumulator is saturated to DATA_W bits and placed on a flat output bus.
//
// Optional build macro: FC_RELU_EN
//   When defined, negative saturated results are forced to zero (ReLU).
//   Latency is the same with or without the macro.
//
// Ports
//   clk, rst    clock; asynchronous active-high reset
//   start       begin a run (sampled only in IDLE)
//   num_in      number of activations this run (latched at start)
//   w_base      weight base address (latched at start)
//   in_pix      input activation, qualified by in_valid; in_ready = accepted
//   w_en/w_addr weight ROM read request; w_data returns one cycle later
//   out_flat    neuron k at bits [k*DATA_W +: DATA_W], qualified by out_valid
//   done        one-cycle completion pulse
//   busy        FSM is not idle
// -----------------------------------------------------------------------------
module fc_layer_mac #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 32,
    parameter int N_IN   = 64,
    parameter int N_OUT  = 10,
    parameter int ADDR_W = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [$clog2(N_IN+1)-1:0] num_in,
    input  logic [ADDR_W-1:0]         w_base,
    input  logic [DATA_W-1:0]         in_pix,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      w_en,
    output logic [ADDR_W-1:0]         w_addr,
    input  logic [DATA_W-1:0]         w_data,
    output logic [N_OUT*DATA_W-1:0]   out_flat,
    output logic                      out_valid,
    output logic                      done,
    output logic                      busy
);

    localparam int CNT_W = $clog2(N_IN+1);
    localparam int K_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N_OUT-1);

    // Signed DATA_W limits, sign-extended to accumulator width for comparison.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           num_q;
    logic [CNT_W-1:0]           idx_q;
    logic [CNT_W-1:0]           idx_next;
    logic [ADDR_W-1:0]          row_q;       // w_base + idx*N_OUT, wraps at ADDR_W
    logic [K_W-1:0]             k_q;         // neuron being requested this cycle
    logic [K_W-1:0]             rd_k_q;      // neuron whose weight is on w_data
    logic                       rd_valid_q;  // w_data carries a requested weight
    logic signed [DATA_W-1:0]   pix_q;
    logic                       w_en_q;
    logic [ADDR_W-1:0]          w_addr_q;
    logic                       in_ready_q;
    logic                       done_q;
    logic                       out_valid_q;
    logic [N_OUT*DATA_W-1:0]    out_flat_q;
    logic [N_OUT*DATA_W-1:0]    out_flat_d;
    logic signed [ACC_W-1:0]    acc_q [N_OUT];
    logic signed [ACC_W-1:0]    acc_d [N_OUT];

    logic signed [2*DATA_W-1:0] prod_full;
    logic signed [2*DATA_W-1:0] prod_shr;
    logic signed [ACC_W-1:0]    prod_ext;

    // Saturate an accumulator to the signed output range. The optional ReLU
    // is applied after saturation.
    function automatic logic [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
        logic [DATA_W-1:0] r;
        if (a > SAT_MAX)      r = {1'b0, {(DATA_W-1){1'b1}}};
        else if (a < SAT_MIN) r = {1'b1, {(DATA_W-1){1'b0}}};
        else                  r = a[DATA_W-1:0];
`ifdef FC_RELU_EN
        if (r[DATA_W-1]) r = '0;
`else
        r = r;
`endif
        return r;
    endfunction

    // Q-format product of the held activation and the returned weight.
    always_comb begin
        prod_full = (2*DATA_W)'(pix_q) * (2*DATA_W)'($signed(w_data));
        prod_shr  = prod_full >>> FRAC_W;
        prod_ext  = ACC_W'(prod_shr);
    end

    assign idx_next = idx_q + CNT_W'(1);

    always_comb begin
        // NOTE: every variable gets a default at the top of a combinational block so no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (num_in == '0) ? S_DONE : S_LOAD;
            S_LOAD:  if (in_valid && in_ready_q) state_d = S_MAC;
            S_MAC:   if (k_q == K_LAST) state_d = S_DRAIN;
            S_DRAIN: state_d = (idx_next == num_q) ? S_DONE : S_LOAD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next accumulator values. The output conversion is computed from these
    // rather than from acc_q. On the same edge that enters DONE, the final
    // neuron's update is still being written, so acc_q would be one update
    // short at that point.
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            if (state_q == S_IDLE && start)
                acc_d[k] = '0;
            else if (rd_valid_q && rd_k_q == K_W'(k))
                acc_d[k] = acc_q[k] + prod_ext;
            else
                acc_d[k] = acc_q[k];
        end
        for (int k = 0; k < N_OUT; k++) begin
            out_flat_d[k*DATA_W +: DATA_W] = sat_out(acc_d[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            num_q       <= '0;
            idx_q       <= '0;
            row_q       <= '0;
            k_q         <= '0;
            rd_k_q      <= '0;
            rd_valid_q  <= 1'b0;
            pix_q       <= '0;
            w_en_q      <= 1'b0;
            w_addr_q    <= '0;
            in_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_flat_q  <= '0;
            // NOTE: the accumulators are a small register array, not a RAM, so resetting them is legal and intended.
            for (int k = 0; k < N_OUT; k++) acc_q[k] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            state_q    <= state_d;
            rd_valid_q <= w_en_q;
            rd_k_q     <= k_q;
            done_q     <= (state_d == S_DONE);
            in_ready_q <= (state_d == S_LOAD);
            for (int k = 0; k < N_OUT; k++) acc_q[k] <= acc_d[k];

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_q       <= num_in;
                        row_q       <= w_base;
                        idx_q       <= '0;
                        out_valid_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (in_valid && in_ready_q) begin
                        pix_q    <= $signed(in_pix);
                        k_q      <= '0;
                        w_en_q   <= 1'b1;
                        w_addr_q <= row_q;
                    end
                end
                S_MAC: begin
                    if (k_q == K_LAST) begin
                        w_en_q <= 1'b0;
                    end else begin
                        k_q      <= k_q + K_W'(1);
                        w_addr_q <= w_addr_q + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    idx_q <= idx_next;
                    row_q <= row_q + ADDR_W'(N_OUT);
                end
                default: ;
            endcase

            // Result registers load on DONE entry. For num_in==0 this happens
            // on the start edge itself, and this later assignment overrides
            // the out_valid clear made above.
            if (state_d == S_DONE && state_q != S_DONE) begin
                out_flat_q  <= out_flat_d;
                out_valid_q <= 1'b1;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign w_en      = w_en_q;
    assign w_addr    = w_addr_q;
    assign out_flat  = out_flat_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fc_layer_mac.sv
// -----------------------------------------------------------------------------
// tb_fc_layer_mac
// Directed, table-driven bench for fc_layer_mac with N_OUT=4. A behavioural
// synchronous ROM supplies the weights. Each table row gives the stimulus and
// the hand-computed outputs and latency for that run. Two hand-written
// sequences cover reset applied mid-run and the rerun that follows it.
// -----------------------------------------------------------------------------
module tb_fc_layer_mac;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int NO = 4;
    localparam int NI = 8;
    localparam int CW = $clog2(NI+1);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CW-1:0]     num_in;
    logic [AW-1:0]     w_base;
    logic [DW-1:0]     in_pix;
    logic              in_valid;
    logic              in_ready;
    logic              w_en;
    logic [AW-1:0]     w_addr;
    logic [DW-1:0]     w_data;
    logic [NO*DW-1:0]  out_flat;
    logic              out_valid;
    logic              done;
    logic              busy;

    logic [DW-1:0]     rom [1 << AW];

    int checks = 0;
    int errors = 0;

    logic [NO-1:0][DW-1:0] prev_flat;

    typedef struct {
        int                    num;
        logic [AW-1:0]         base;
        logic [NO-1:0][DW-1:0] pix;
        logic [NO-1:0][DW-1:0] wts;        // weight per neuron, same for every input
        int                    gap;        // in_valid-low LOAD cycles before pixel 2
        int                    busy_start; // cycle at which a stray start is pulsed
        logic [NO-1:0][DW-1:0] exp;        // expected outputs before optional ReLU
        int                    exp_cyc;    // start edge to done, in cycles
    } vec_t;

    vec_t vecs[8];

    fc_layer_mac #(
        .DATA_W(DW), .FRAC_W(8), .ACC_W(32), .N_IN(NI), .N_OUT(NO), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_in(num_in), .w_base(w_base),
        .in_pix(in_pix), .in_valid(in_valid), .in_ready(in_ready),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .out_flat(out_flat), .out_valid(out_valid), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous weight ROM with one cycle of read latency.
    always @(posedge clk) begin
        if (w_en) w_data <= rom[w_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] relu_adj(input logic [DW-1:0] x);
`ifdef FC_RELU_EN
        return x[DW-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    task automatic fill_rom(input vec_t v);
        logic [AW-1:0] a;
        for (int i = 0; i < v.num; i++) begin
            for (int k = 0; k < NO; k++) begin
                a = v.base + AW'(i*NO + k);
                rom[a] = v.wts[k];
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int   cyc, pix_idx, addr_cnt, gap_left;
        bit   gap_started, prev_valid, prev_ready, seen_done;
        logic [AW-1:0] ea;
        fill_rom(v);
        @(negedge clk);
        start = 1'b1; num_in = CW'(v.num); w_base = v.base; in_valid = 1'b0;
        cyc = 0; pix_idx = 0; addr_cnt = 0; gap_left = 0;
        gap_started = 0; prev_valid = 0; prev_ready = 0; seen_done = 0;
        while (!seen_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1 && v.num > 0) begin
                // Accepted start clears out_valid but leaves the old result.
                check($sformatf("v%0d out_valid_cleared", vi), 64'(out_valid), 64'd0);
                check($sformatf("v%0d out_flat_held", vi), 64'(out_flat), 64'(prev_flat));
            end
            if (v.busy_start > 0 && cyc == v.busy_start) begin
                start = 1'b1; num_in = CW'(1); w_base = 12'h777;
            end
            if (prev_valid && prev_ready) pix_idx++;
            if (v.gap > 0 && pix_idx == 1 && in_ready && !gap_started) begin
                gap_started = 1;
                gap_left    = v.gap;
            end
            if (gap_left > 0) begin
                check($sformatf("v%0d gap_in_ready", vi), 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                gap_left--;
            end else if (pix_idx < v.num) begin
                in_valid = 1'b1;
                in_pix   = v.pix[pix_idx];
            end else begin
                in_valid = 1'b0;
            end
            prev_valid = in_valid;
            prev_ready = in_ready;
            if (w_en) begin
                ea = v.base + AW'(addr_cnt);
                check($sformatf("v%0d w_addr[%0d]", vi, addr_cnt), 64'(w_addr), 64'(ea));
                addr_cnt++;
            end
            if (done) seen_done = 1;
        end
        in_valid = 1'b0;
        check($sformatf("v%0d done_seen", vi), 64'(seen_done), 64'd1);
        if (seen_done) begin
            check($sformatf("v%0d latency", vi), 64'(cyc), 64'(v.exp_cyc));
            check($sformatf("v%0d out_valid", vi), 64'(out_valid), 64'd1);
            check($sformatf("v%0d busy_in_done", vi), 64'(busy), 64'd1);
            for (int k = 0; k < NO; k++)
                check($sformatf("v%0d out[%0d]", vi, k),
                      64'(out_flat[k*DW +: DW]), 64'(relu_adj(v.exp[k])));
            check($sformatf("v%0d weight_reads", vi), 64'(addr_cnt), 64'(v.num*NO));
            @(negedge clk);
            check($sformatf("v%0d done_pulse", vi), 64'(done), 64'd0);
            check($sformatf("v%0d idle", vi), 64'(busy), 64'd0);
            check($sformatf("v%0d out_valid_hold", vi), 64'(out_valid), 64'd1);
        end
        for (int k = 0; k < NO; k++) prev_flat[k] = relu_adj(v.exp[k]);
    endtask

    initial begin
        int n;
        vecs[0] = '{num: 2, base: 12'h010, pix: {16'h0000, 16'h0000, 16'h0200, 16'h0100},
                    wts: {4{16'h0100}}, gap: 0, busy_start: 0, exp: {4{16'h0300}}, exp_cyc: 13};
        vecs[1] = '{num: 4, base: 12'h100, pix: {4{16'h7FFF}},
                    wts: {4{16'h7FFF}}, gap: 0, busy_start: 0, exp: {4{16'h7FFF}}, exp_cyc: 25};
        vecs[2] = '{num: 4, base: 12'h200, pix: {4{16'h7FFF}},
                    wts: {4{16'h8001}}, gap: 0, busy_start: 0, exp: {4{16'h8000}}, exp_cyc: 25};
        vecs[3] = '{num: 2, base: 12'h300, pix: {16'h0000, 16'h0000, 16'h0200, 16'h0100},
                    wts: {4{16'h0100}}, gap: 5, busy_start: 0, exp: {4{16'h0300}}, exp_cyc: 18};
        vecs[4] = '{num: 0, base: 12'h400, pix: {4{16'h0000}},
                    wts: {4{16'h0000}}, gap: 0, busy_start: 0, exp: {4{16'h0000}}, exp_cyc: 1};
        vecs[5] = '{num: 1, base: 12'hFFE, pix: {16'h0000, 16'h0000, 16'h0000, 16'h0100},
                    wts: {4{16'hFF00}}, gap: 0, busy_start: 0, exp: {4{16'hFF00}}, exp_cyc: 7};
        vecs[6] = '{num: 3, base: 12'h020, pix: {16'h0000, 16'hFF00, 16'h0080, 16'h0100},
                    wts: {16'h0040, 16'hFE00, 16'h0200, 16'h0100}, gap: 0, busy_start: 0,
                    exp: {16'h0020, 16'hFF00, 16'h0100, 16'h0080}, exp_cyc: 19};
        vecs[7] = '{num: 2, base: 12'h010, pix: {16'h0000, 16'h0000, 16'h0200, 16'h0100},
                    wts: {4{16'h0100}}, gap: 0, busy_start: 4, exp: {4{16'h0300}}, exp_cyc: 13};

        rst = 1'b1; start = 1'b0; num_in = '0; w_base = '0; in_pix = '0; in_valid = 1'b0;
        prev_flat = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset w_en", 64'(w_en), 64'd0);
        check("reset w_addr", 64'(w_addr), 64'd0);
        check("reset out_flat", 64'(out_flat), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset in the middle of the MAC phase must clear everything at once.
        fill_rom(vecs[0]);
        @(negedge clk);
        start = 1'b1; num_in = CW'(2); w_base = vecs[0].base;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_pix = 16'h0100;
        n = 0;
        while (n < 20 && !w_en) begin
            @(negedge clk);
            n++;
        end
        check("midrun reached_mac", 64'(w_en), 64'd1);
        @(negedge clk);
        check("midrun busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("midrun busy", 64'(busy), 64'd0);
        check("midrun w_en", 64'(w_en), 64'd0);
        check("midrun w_addr", 64'(w_addr), 64'd0);
        check("midrun in_ready", 64'(in_ready), 64'd0);
        check("midrun done", 64'(done), 64'd0);
        check("midrun out_valid", 64'(out_valid), 64'd0);
        check("midrun out_flat", 64'(out_flat), 64'd0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prev_flat = '0;

        // A fresh run after the abort reproduces the first result.
        run_vec(vecs[0], 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
